sobol_fp16_arbiter: RTL and testbench

Shares one combinational INT32→FP16 converter (5-bit exponent, 11-bit mantissa, unsigned) among N_REQ Sobol dimension generators. Requesters offer 32-bit samples over valid/ready; the block grants them round-robin, registers the winner into the converter input, captures the converter result with the requester ID, and presents it downstream over valid/ready. It sits between the per-dimension Sobol cores and the FP16 consumer. Sustained throughput is one sample per cycle, with full backpressure.

---
 rtl/sobol_fp16_arbiter.sv | 139 +++++++++++++
 tb/tb_sobol_fp16_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobol_fp16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sobol_fp16_arbiter
// Brief    : Round-robin share of one INT32->FP16 converter among N_REQ Sobol
//            generators, with a two-stage valid/ready pipeline to the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module sobol_fp16_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]      req_mask,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           conv_int32,
    input  logic [15:0]           conv_fp16,
    output logic                  out_valid,
    output logic [15:0]           out_fp16,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      out_count,
    output logic                  busy
);

    localparam logic [ID_W:0]   c_N_REQ   = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(N_REQ - 1);

    logic [31:0]      r_s1_data;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s1_valid;
    logic [15:0]      r_out_fp16;
    logic [ID_W-1:0]  r_out_id;
    logic             r_out_valid;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_req_data [N_REQ];
    logic [N_REQ-1:0] w_eligible;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W:0]    w_scan;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_next_ptr;
    logic             w_found;
    logic             w_s1_adv;
    logic             w_s1_load;
    logic             w_accept;
    logic             w_out_fire;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
            assign w_req_data[i] = req_data[32*i +: 32];
        end
    endgenerate

    assign w_eligible = req_valid & req_mask;
    assign w_s1_adv   = r_s1_valid & (~r_out_valid | out_ready);
    assign w_s1_load  = ~r_s1_valid | w_s1_adv;
    assign w_out_fire = r_out_valid & out_ready;

    // Scan from rr_ptr upward with wrap; first eligible index wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + k[ID_W:0];
            if (w_scan >= c_N_REQ) begin
                w_scan = w_scan - c_N_REQ;
            end
            if (!w_found && w_eligible[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign req_ready  = w_grant & {N_REQ{w_s1_load}};
    assign w_accept   = w_found & w_s1_load;
    assign w_next_ptr = (w_win == c_LAST_ID) ? '0 : w_win + 1'b1;

    // S1: holds the granted sample on the converter input until S2 can take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_id    <= '0;
            r_s1_valid <= 1'b0;
            r_rr_ptr   <= '0;
        end else if (w_accept) begin
            r_s1_data  <= w_req_data[w_win];
            r_s1_id    <= w_win;
            r_s1_valid <= 1'b1;
            r_rr_ptr   <= w_next_ptr;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_fp16  <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_fp16  <= conv_fp16;
            r_out_id    <= r_s1_id;
            r_out_valid <= 1'b1;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_out_fire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign conv_int32 = r_s1_data;
    assign out_valid  = r_out_valid;
    assign out_fp16   = r_out_fp16;
    assign out_id     = r_out_id;
    assign out_count  = r_count;
    assign busy       = r_s1_valid | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sobol_fp16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobol_fp16_arbiter
// Brief    : Directed self-checking bench for sobol_fp16_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobol_fp16_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_mask;
    logic [3:0]   req_ready;
    logic [31:0]  conv_int32;
    logic [15:0]  conv_fp16;
    logic         out_valid;
    logic [15:0]  out_fp16;
    logic [1:0]   out_id;
    logic         out_ready;
    logic [15:0]  out_count;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Shared converter: exponent = MSB position (floor 10), 11-bit mantissa with explicit leading one.
    function automatic logic [15:0] cvt(input logic [31:0] v);
        int p;
        p = -1;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        if (p < 10) return {5'd10, v[10:0]};
        return {p[4:0], 11'(v >> (p - 10))};
    endfunction

    assign conv_fp16 = cvt(conv_int32);

    sobol_fp16_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .req_ready  (req_ready),
        .conv_int32 (conv_int32),
        .conv_fp16  (conv_fp16),
        .out_valid  (out_valid),
        .out_fp16   (out_fp16),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_mask = 4'hF; req_data = '0; out_ready = 1'b1;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_fp16 !== 16'h0) begin n_fails++; $display("FAIL reset_out_fp16: got %h want 0000", out_fp16); end
        n_checks++; if (out_id !== 2'd0) begin n_fails++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
        n_checks++; if (conv_int32 !== 32'h0) begin n_fails++; $display("FAIL reset_conv_int32: got %h want 0", conv_int32); end
        n_checks++; if (out_count !== 16'h0) begin n_fails++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_data[31:0] = 32'h8000_0000; req_valid = 4'b0001; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fails++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        step(); req_valid = '0; #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fails++; $display("FAIL single_t1: got valid %b busy %b want 0 1", out_valid, busy); end
        n_checks++; if (conv_int32 !== 32'h8000_0000) begin n_fails++; $display("FAIL single_conv: got %h want 80000000", conv_int32); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_fp16 !== 16'hFC00 || out_id !== 2'd0) begin n_fails++; $display("FAIL single_out: got v%b %h id%0d want v1 fc00 id0", out_valid, out_fp16, out_id); end
        step();
        n_checks++; if (out_count !== 16'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL single_done: got cnt %0d v%b busy %b want 1 0 0", out_count, out_valid, busy); end
    endtask

    task automatic test_small_values();
        req_data[95:64] = 32'h0000_0000; req_valid = 4'b0100; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fails++; $display("FAIL small_ready0: got %b want 0100", req_ready); end
        step(); req_data[95:64] = 32'h0000_0FFF; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fails++; $display("FAIL small_ready1: got %b want 0100", req_ready); end
        step(); req_valid = '0; #1;
        n_checks++; if (out_valid !== 1'b1 || out_fp16 !== 16'h5000 || out_id !== 2'd2) begin n_fails++; $display("FAIL small_out0: got v%b %h id%0d want v1 5000 id2", out_valid, out_fp16, out_id); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_fp16 !== 16'h5FFF || out_id !== 2'd2) begin n_fails++; $display("FAIL small_out1: got v%b %h id%0d want v1 5fff id2", out_valid, out_fp16, out_id); end
        step();
        n_checks++; if (out_count !== 16'd3 || out_valid !== 1'b0) begin n_fails++; $display("FAIL small_count: got %0d v%b want 3 0", out_count, out_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_r;
        do_reset();
        req_mask = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h4000_0000 | i;
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_r = 4'b0001 << (c % 4);
            n_checks++; if (req_ready !== exp_r) begin n_fails++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, exp_r); end
            if (c >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_fp16 !== 16'hF400 || out_id !== 2'((c - 2) % 4)) begin
                    n_fails++; $display("FAIL rr_out c%0d: got v%b %h id%0d want v1 f400 id%0d", c, out_valid, out_fp16, out_id, (c - 2) % 4);
                end
            end
            step();
        end
        req_valid = '0;
        step(); step(); step();
    endtask

    task automatic test_back_to_back_backpressure();
        do_reset();
        req_mask = 4'hF; out_ready = 1'b0;
        req_data[31:0] = 32'd1; req_data[63:32] = 32'd2; req_data[95:64] = 32'd3;
        req_valid = 4'b0111; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fails++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
        step(); req_valid = 4'b0110; #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fails++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
        step(); req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_fp16 !== 16'h5001 || out_id !== 2'd0 || conv_int32 !== 32'd2) begin
                n_fails++; $display("FAIL bp_hold c%0d: got rdy %b v%b %h id%0d conv %h want 0000 v1 5001 id0 2", c, req_ready, out_valid, out_fp16, out_id, conv_int32);
            end
            step();
        end
        out_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fails++; $display("FAIL bp_release_grant: got %b want 0100", req_ready); end
        step(); req_valid = '0; #1;
        n_checks++; if (out_fp16 !== 16'h5002 || out_id !== 2'd1 || out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_out1: got v%b %h id%0d want v1 5002 id1", out_valid, out_fp16, out_id); end
        step();
        n_checks++; if (out_fp16 !== 16'h5003 || out_id !== 2'd2 || out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_out2: got v%b %h id%0d want v1 5003 id2", out_valid, out_fp16, out_id); end
        step();
        n_checks++; if (out_count !== 16'd3 || busy !== 1'b0) begin n_fails++; $display("FAIL bp_drain: got cnt %0d busy %b want 3 0", out_count, busy); end
    endtask

    task automatic test_mask_skip();
        logic [3:0] exp_r;
        do_reset();
        req_mask = 4'b1010; out_ready = 1'b1; req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_r = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            n_checks++; if (req_ready !== exp_r) begin n_fails++; $display("FAIL mask_grant c%0d: got %b want %b", c, req_ready, exp_r); end
            if (c >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_id !== ((c % 2 == 0) ? 2'd1 : 2'd3)) begin
                    n_fails++; $display("FAIL mask_out c%0d: got v%b id%0d want v1 id%0d", c, out_valid, out_id, (c % 2 == 0) ? 1 : 3);
                end
            end
            step();
        end
        req_mask = 4'b1110; #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fails++; $display("FAIL mask_same_cycle: got %b want 0010", req_ready); end
        req_valid = '0; #1;
        step();
        req_mask = 4'hF; req_valid = 4'hF; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fails++; $display("FAIL mask_ptr_kept: got %b want 0001", req_ready); end
        req_valid = '0;
        step(); step(); step();
    endtask

    task automatic test_count_wrap();
        int hs;
        int cyc;
        logic pend;
        do_reset();
        req_mask = 4'hF; out_ready = 1'b1; req_valid = 4'hF;
        hs = 0; cyc = 0;
        while (hs < 65535 && cyc < 70000) begin
            pend = out_valid;
            step();
            cyc++;
            if (pend) hs++;
        end
        n_checks++; if (hs != 65535) begin n_fails++; $display("FAIL wrap_budget: got %0d handshakes want 65535", hs); end
        n_checks++; if (out_count !== 16'hFFFF || out_valid !== 1'b1) begin n_fails++; $display("FAIL wrap_max: got %h v%b want ffff v1", out_count, out_valid); end
        step();
        n_checks++; if (out_count !== 16'h0000) begin n_fails++; $display("FAIL wrap_zero: got %h want 0000", out_count); end
        req_valid = '0;
        step(); step(); step();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        req_mask = 4'hF; out_ready = 1'b0;
        req_data[31:0] = 32'h10; req_data[63:32] = 32'h20;
        req_valid = 4'b0011;
        step(); req_valid = 4'b0010;
        step(); req_valid = '0; #1;
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1 || out_id !== 2'd0) begin n_fails++; $display("FAIL mid_full: got v%b busy %b id%0d want 1 1 0", out_valid, busy, out_id); end
        rst = 1'b1; out_ready = 1'b1; req_valid = 4'hF;
        step();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 16'd0) begin n_fails++; $display("FAIL mid_reset: got v%b busy %b cnt %0d want 0 0 0", out_valid, busy, out_count); end
        n_checks++; if (conv_int32 !== 32'h0 || out_fp16 !== 16'h0) begin n_fails++; $display("FAIL mid_reset_data: got conv %h fp %h want 0 0", conv_int32, out_fp16); end
        rst = 1'b0; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fails++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        step(); req_valid = '0; #1;
        n_checks++; if (conv_int32 !== 32'h10) begin n_fails++; $display("FAIL mid_first_data: got %h want 00000010", conv_int32); end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_small_values();
        test_round_robin();
        test_back_to_back_backpressure();
        test_mask_skip();
        test_count_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
